// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, the request-slot layout and the legality check
// used by the single-transfer manager.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic [2:0]  size;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    // ST_ERR: between the two ERROR cycles; ST_FLUSH: draining queued requests as errors.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ERR   = 2'd1,
        ST_FLUSH = 2'd2
    } err_state_e;

    function automatic logic req_illegal(input logic [31:0] addr, input logic [2:0] size);
        logic bad;
        bad = 1'b1;
        case (size)
            HSIZE_BYTE: bad = 1'b0;
            HSIZE_HALF: bad = addr[0];
            HSIZE_WORD: bad = (addr[1:0] != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with pop-before-push: a full FIFO may accept a push in the
// same cycle it is popped.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

endmodule

// File: rtl/ahb_single_master.sv
// AHB-Lite manager issuing single transfers from a request FIFO through an
// address slot (A) and a data slot (D), with two-cycle ERROR handling.
module ahb_single_master
    import ahb_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter bit FLUSH_ON_ERROR = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic [7:0]  err_count,
    output logic [31:0] haddr_m,
    output logic [2:0]  hburst_m,
    output logic [2:0]  hsize_m,
    output logic [1:0]  htrans_m,
    output logic [31:0] hwdata_m,
    output logic        hwrite_m,
    input  logic [31:0] hrdata_m,
    input  logic        hready_m,
    input  logic        hresp_m,
    output err_state_e  dbg_state
);

    // Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
    // rsp_valid is a single-cycle pulse with no backpressure.

    localparam req_t REQ_RESET = '{addr: 32'h0, wdata: 32'h0, write: 1'b0, size: HSIZE_WORD};

    err_state_e state_q, state_d;
    logic       a_valid_q, a_valid_d, a_bad_q, a_bad_d;
    logic       d_valid_q, d_valid_d, d_bad_q, d_bad_d;
    req_t       a_req_q, a_req_d, d_req_q, d_req_d;
    logic       rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [7:0] err_count_q, err_count_d;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [REQ_W-1:0] fifo_rdata;
    req_t             fifo_head, in_req;
    logic             bypass;

    assign in_req    = '{addr: req_addr, wdata: req_wdata, write: req_write, size: req_size};
    assign fifo_head = fifo_rdata;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (in_req),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        a_valid_d   = a_valid_q;
        a_bad_d     = a_bad_q;
        a_req_d     = a_req_q;
        d_valid_d   = d_valid_q;
        d_bad_d     = d_bad_q;
        d_req_d     = d_req_q;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        rsp_rdata_d = '0;
        fifo_pop    = 1'b0;
        fifo_push   = 1'b0;
        req_ready   = 1'b0;
        bypass      = 1'b0;

        case (state_q)
            ST_RUN: begin
                // When full, the head leaves exactly when a new address phase launches.
                req_ready = !fifo_full || (hready_m && ce);
                if (hready_m) begin
                    if (d_valid_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = d_bad_q || (hresp_m == HRESP_ERROR);
                        rsp_rdata_d = (!d_req_q.write && !rsp_error_d) ? hrdata_m : 32'h0;
                    end
                    d_valid_d = a_valid_q;
                    d_bad_d   = a_bad_q;
                    if (a_valid_q) begin
                        d_req_d = a_req_q;
                    end
                    a_valid_d = 1'b0;
                    if (ce) begin
                        if (!fifo_empty) begin
                            fifo_pop  = 1'b1;
                            a_valid_d = 1'b1;
                            a_req_d   = fifo_head;
                            a_bad_d   = req_illegal(fifo_head.addr, fifo_head.size);
                        end else if (req_valid) begin
                            // Empty FIFO: the new request goes straight to the address slot.
                            bypass    = 1'b1;
                            a_valid_d = 1'b1;
                            a_req_d   = in_req;
                            a_bad_d   = req_illegal(req_addr, req_size);
                        end
                    end
                end else if (d_valid_q && !d_bad_q && (hresp_m == HRESP_ERROR)) begin
                    state_d = ST_ERR;
                end
                fifo_push = req_valid && req_ready && !bypass;
            end

            ST_ERR: begin
                req_ready = !fifo_full;
                fifo_push = req_valid && req_ready;
                if (hready_m) begin
                    if (d_valid_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end
                    d_valid_d = 1'b0;
                    state_d   = FLUSH_ON_ERROR ? ST_FLUSH : ST_RUN;
                end
            end

            ST_FLUSH: begin
                if (a_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    a_valid_d   = 1'b0;
                end else if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end

            default: state_d = ST_RUN;
        endcase

        err_count_d = err_count_q;
        if (rsp_valid_d && rsp_error_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            a_valid_q   <= 1'b0;
            a_bad_q     <= 1'b0;
            a_req_q     <= REQ_RESET;
            d_valid_q   <= 1'b0;
            d_bad_q     <= 1'b0;
            d_req_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            a_valid_q   <= a_valid_d;
            a_bad_q     <= a_bad_d;
            a_req_q     <= a_req_d;
            d_valid_q   <= d_valid_d;
            d_bad_q     <= d_bad_d;
            d_req_q     <= d_req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_count_q <= err_count_d;
        end
    end

    // Illegal entries ride the slots for timing but are never shown as NONSEQ.
    assign htrans_m  = (state_q == ST_RUN && a_valid_q && !a_bad_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr_m   = a_req_q.addr;
    assign hsize_m   = a_req_q.size;
    assign hwrite_m  = a_req_q.write;
    assign hburst_m  = HBURST_SINGLE;
    assign hwdata_m  = d_req_q.wdata;
    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_rdata = rsp_rdata_q;
    assign err_count = err_count_q;
    assign busy      = a_valid_q || d_valid_q || !fifo_empty || (state_q != ST_RUN);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_single_master.sv
// Directed bench for ahb_single_master: one instance without and one with
// flush-on-error, driven by per-cycle stimulus tables.
module tb_ahb_single_master;
    import ahb_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, ce, req_valid, req_write, hready_m, hresp_m;
    logic [31:0] req_addr, req_wdata, hrdata_m;
    logic [2:0]  req_size;

    logic        req_ready0, rsp_valid0, rsp_error0, busy0, hwrite0;
    logic [31:0] rsp_rdata0, haddr0, hwdata0;
    logic [7:0]  err_count0;
    logic [2:0]  hburst0, hsize0;
    logic [1:0]  htrans0;
    err_state_e  dbg0;

    logic        req_ready1, rsp_valid1, rsp_error1, busy1, hwrite1;
    logic [31:0] rsp_rdata1, haddr1, hwdata1;
    logic [7:0]  err_count1;
    logic [2:0]  hburst1, hsize1;
    logic [1:0]  htrans1;
    err_state_e  dbg1;

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;
    logic [64:0] rsp0_q[$];
    logic [64:0] rsp1_q[$];
    int ns0 = 0;

    always #5 clk = ~clk;

    ahb_single_master #(.FIFO_DEPTH(4), .FLUSH_ON_ERROR(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .req_valid(req_valid), .req_ready(req_ready0),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write), .req_size(req_size),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_error(rsp_error0), .busy(busy0),
        .err_count(err_count0), .haddr_m(haddr0), .hburst_m(hburst0), .hsize_m(hsize0),
        .htrans_m(htrans0), .hwdata_m(hwdata0), .hwrite_m(hwrite0), .hrdata_m(hrdata_m),
        .hready_m(hready_m), .hresp_m(hresp_m), .dbg_state(dbg0)
    );

    ahb_single_master #(.FIFO_DEPTH(4), .FLUSH_ON_ERROR(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .req_valid(req_valid), .req_ready(req_ready1),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write), .req_size(req_size),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_error(rsp_error1), .busy(busy1),
        .err_count(err_count1), .haddr_m(haddr1), .hburst_m(hburst1), .hsize_m(hsize1),
        .htrans_m(htrans1), .hwdata_m(hwdata1), .hwrite_m(hwrite1), .hrdata_m(hrdata_m),
        .hready_m(hready_m), .hresp_m(hresp_m), .dbg_state(dbg1)
    );

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Response log entries are {cycle, error, rdata}.
    always @(negedge clk) begin
        if (rsp_valid0) rsp0_q.push_back({32'(cyc_cnt), rsp_error0, rsp_rdata0});
        if (rsp_valid1) rsp1_q.push_back({32'(cyc_cnt), rsp_error1, rsp_rdata1});
        if (htrans0 == HTRANS_NONSEQ) ns0++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ce        = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_write = 1'b0;
        req_size  = HSIZE_WORD;
        hready_m  = 1'b1;
        hresp_m   = 1'b0;
        hrdata_m  = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) cyc();
        reset_n = 1'b1;
        cyc();
        rsp0_q.delete();
        rsp1_q.delete();
        ns0 = 0;
    endtask

    task automatic test_reset();
        logic [116:0] obs, exp;
        do_reset();
        @(negedge clk);
        exp = {2'b00, 32'h0, 3'd2, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b1};
        obs = {htrans0, haddr0, hsize0, hwrite0, hburst0, hwdata0, rsp_valid0, rsp_rdata0,
               rsp_error0, busy0, err_count0, req_ready0};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_dut0 got=%h want=%h", obs, exp); end
        obs = {htrans1, haddr1, hsize1, hwrite1, hburst1, hwdata1, rsp_valid1, rsp_rdata1,
               rsp_error1, busy1, err_count1, req_ready1};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_dut1 got=%h want=%h", obs, exp); end
    endtask

    task automatic test_single_write();
        logic [37:0] obs, exp;
        do_reset();
        req_valid = 1'b1; req_addr = 32'h1000; req_wdata = 32'hDEADBEEF;
        req_write = 1'b1; req_size = HSIZE_WORD;
        @(negedge clk);
        total++;
        if (req_ready0 !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b want=1", req_ready0); end
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        obs = {htrans0, haddr0, hwrite0, hsize0};
        exp = {HTRANS_NONSEQ, 32'h1000, 1'b1, HSIZE_WORD};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL wr_addr_phase got=%h want=%h", obs, exp); end
        cyc();
        @(negedge clk);
        total++;
        if ({htrans0, hwdata0, rsp_valid0} !== {HTRANS_IDLE, 32'hDEADBEEF, 1'b0}) begin
            bad++; $display("FAIL wr_data_phase got=%h want=%h", {htrans0, hwdata0, rsp_valid0},
                            {HTRANS_IDLE, 32'hDEADBEEF, 1'b0});
        end
        cyc();
        @(negedge clk);
        total++;
        if ({rsp_valid0, rsp_error0, rsp_rdata0} !== {1'b1, 1'b0, 32'h0}) begin
            bad++; $display("FAIL wr_rsp got=%h want=%h", {rsp_valid0, rsp_error0, rsp_rdata0},
                            {1'b1, 1'b0, 32'h0});
        end
        cyc();
        @(negedge clk);
        total++;
        if ({rsp_valid0, busy0} !== 2'b00) begin
            bad++; $display("FAIL wr_single_pulse got=%b want=00", {rsp_valid0, busy0});
        end
    endtask

    task automatic test_back_to_back();
        logic [0:9]  rdy = 10'b1110011111;
        logic [31:0] rd_tab [10] = '{32'h0, 32'h0, 32'h11, 32'h0, 32'h0,
                                     32'h22, 32'h33, 32'h44, 32'h0, 32'h0};
        logic [64:0] exp_q[$];
        logic [64:0] got, exp;
        int t0;
        do_reset();
        t0 = cyc_cnt;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) cyc();
            req_valid = (k < 4);
            req_addr  = 32'h100 + 32'(4 * k);
            req_write = 1'b0;
            req_size  = HSIZE_WORD;
            hready_m  = rdy[k];
            hrdata_m  = rd_tab[k];
            @(negedge clk);
            if (k == 3 || k == 4) begin
                total++;
                if ({htrans0, haddr0} !== {HTRANS_NONSEQ, 32'h108}) begin
                    bad++; $display("FAIL b2b_wait_hold c%0d got=%h want=%h", k,
                                    {htrans0, haddr0}, {HTRANS_NONSEQ, 32'h108});
                end
            end
        end
        cyc();
        exp_q.push_back({32'(t0 + 3), 1'b0, 32'h11});
        exp_q.push_back({32'(t0 + 6), 1'b0, 32'h22});
        exp_q.push_back({32'(t0 + 7), 1'b0, 32'h33});
        exp_q.push_back({32'(t0 + 8), 1'b0, 32'h44});
        total++;
        if (rsp0_q.size() != exp_q.size()) begin
            bad++; $display("FAIL b2b_rsp_count got=%0d want=%0d", rsp0_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && rsp0_q.size() > 0) begin
            got = rsp0_q.pop_front();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin bad++; $display("FAIL b2b_rsp got=%h want=%h", got, exp); end
        end
        total++;
        if (ns0 != 6) begin bad++; $display("FAIL b2b_nonseq_cycles got=%0d want=6", ns0); end
    endtask

    task automatic test_error_retry();
        logic [0:7]  rdy  = 8'b11011111;
        logic [0:7]  resp = 8'b00110000;
        logic [64:0] exp_q[$];
        logic [64:0] got, exp;
        int t0;
        do_reset();
        t0 = cyc_cnt;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc();
            req_valid = (k < 2);
            req_addr  = (k == 0) ? 32'h200 : 32'h204;
            req_wdata = 32'hCAFE0001;
            req_write = (k == 0);
            req_size  = HSIZE_WORD;
            hready_m  = rdy[k];
            hresp_m   = resp[k];
            hrdata_m  = (k == 5) ? 32'h55 : 32'h0;
            @(negedge clk);
            if (k == 3) begin
                total++;
                if ({htrans0, dbg0} !== {HTRANS_IDLE, ST_ERR}) begin
                    bad++; $display("FAIL err_idle_cycle got=%h want=%h", {htrans0, dbg0},
                                    {HTRANS_IDLE, ST_ERR});
                end
            end
            if (k == 4) begin
                total++;
                if ({htrans0, haddr0, hwrite0} !== {HTRANS_NONSEQ, 32'h204, 1'b0}) begin
                    bad++; $display("FAIL err_reissue got=%h want=%h", {htrans0, haddr0, hwrite0},
                                    {HTRANS_NONSEQ, 32'h204, 1'b0});
                end
            end
        end
        cyc();
        exp_q.push_back({32'(t0 + 4), 1'b1, 32'h0});
        exp_q.push_back({32'(t0 + 6), 1'b0, 32'h55});
        total++;
        if (rsp0_q.size() != exp_q.size()) begin
            bad++; $display("FAIL err_rsp_count got=%0d want=%0d", rsp0_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && rsp0_q.size() > 0) begin
            got = rsp0_q.pop_front();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin bad++; $display("FAIL err_rsp got=%h want=%h", got, exp); end
        end
        total++;
        if (err_count0 !== 8'd1) begin bad++; $display("FAIL err_count got=%0d want=1", err_count0); end
    endtask

    task automatic test_flush();
        logic [0:9]  rdy  = 10'b1101111111;
        logic [0:9]  resp = 10'b0011000000;
        logic [64:0] exp_q[$];
        logic [64:0] got, exp;
        int t0;
        do_reset();
        t0 = cyc_cnt;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) cyc();
            req_valid = (k < 4);
            req_addr  = 32'h300 + 32'(4 * k);
            req_wdata = 32'(k);
            req_write = 1'b1;
            req_size  = HSIZE_WORD;
            hready_m  = rdy[k];
            hresp_m   = resp[k];
            @(negedge clk);
            if (k >= 3) begin
                total++;
                if (htrans1 !== HTRANS_IDLE) begin
                    bad++; $display("FAIL flush_no_bus c%0d got=%h want=%h", k, htrans1, HTRANS_IDLE);
                end
            end
            if (k == 4) begin
                total++;
                if (dbg1 !== ST_FLUSH) begin bad++; $display("FAIL flush_state got=%0d want=%0d", dbg1, ST_FLUSH); end
            end
            if (k >= 4 && k <= 7) begin
                total++;
                if (req_ready1 !== 1'b0) begin bad++; $display("FAIL flush_ready c%0d got=%b want=0", k, req_ready1); end
            end
            if (k == 8) begin
                total++;
                if ({req_ready1, busy1} !== 2'b10) begin
                    bad++; $display("FAIL flush_end got=%b want=10", {req_ready1, busy1});
                end
            end
        end
        cyc();
        for (int i = 0; i < 4; i++) exp_q.push_back({32'(t0 + 4 + i), 1'b1, 32'h0});
        total++;
        if (rsp1_q.size() != exp_q.size()) begin
            bad++; $display("FAIL flush_rsp_count got=%0d want=%0d", rsp1_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && rsp1_q.size() > 0) begin
            got = rsp1_q.pop_front();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin bad++; $display("FAIL flush_rsp got=%h want=%h", got, exp); end
        end
        total++;
        if (err_count1 !== 8'd4) begin bad++; $display("FAIL flush_err_count got=%0d want=4", err_count1); end
    endtask

    task automatic test_illegal();
        logic [64:0] exp_q[$];
        logic [64:0] got, exp;
        int t0;
        do_reset();
        t0 = cyc_cnt;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cyc();
            req_valid = (k < 2);
            req_addr  = (k == 0) ? 32'h3 : 32'h0;
            req_size  = (k == 0) ? HSIZE_HALF : 3'd3;
            req_write = 1'b0;
            @(negedge clk);
        end
        cyc();
        exp_q.push_back({32'(t0 + 3), 1'b1, 32'h0});
        exp_q.push_back({32'(t0 + 4), 1'b1, 32'h0});
        total++;
        if (rsp0_q.size() != exp_q.size()) begin
            bad++; $display("FAIL illegal_rsp_count got=%0d want=%0d", rsp0_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && rsp0_q.size() > 0) begin
            got = rsp0_q.pop_front();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin bad++; $display("FAIL illegal_rsp got=%h want=%h", got, exp); end
        end
        total++;
        if (ns0 != 0) begin bad++; $display("FAIL illegal_no_bus got=%0d want=0", ns0); end
        total++;
        if (err_count0 !== 8'd2) begin bad++; $display("FAIL illegal_err_count got=%0d want=2", err_count0); end
    endtask

    task automatic test_ce_gate();
        logic [64:0] got, exp;
        int t0;
        do_reset();
        t0 = cyc_cnt;
        hrdata_m = 32'h77;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) cyc();
            req_valid = (k == 0);
            req_addr  = 32'h400;
            req_write = 1'b0;
            req_size  = HSIZE_WORD;
            ce        = (k >= 2);
            @(negedge clk);
            if (k == 1) begin
                total++;
                if ({htrans0, busy0} !== {HTRANS_IDLE, 1'b1}) begin
                    bad++; $display("FAIL ce_hold got=%h want=%h", {htrans0, busy0}, {HTRANS_IDLE, 1'b1});
                end
            end
            if (k == 3) begin
                total++;
                if ({htrans0, haddr0} !== {HTRANS_NONSEQ, 32'h400}) begin
                    bad++; $display("FAIL ce_launch got=%h want=%h", {htrans0, haddr0}, {HTRANS_NONSEQ, 32'h400});
                end
            end
        end
        cyc();
        exp = {32'(t0 + 5), 1'b0, 32'h77};
        total++;
        if (rsp0_q.size() != 1) begin
            bad++; $display("FAIL ce_rsp_count got=%0d want=1", rsp0_q.size());
        end else begin
            got = rsp0_q.pop_front();
            total++;
            if (got !== exp) begin bad++; $display("FAIL ce_rsp got=%h want=%h", got, exp); end
        end
    endtask

    task automatic test_fifo_full_reset();
        logic [115:0] obs, exp;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (k > 0) cyc();
            req_valid = (k < 6);
            req_addr  = 32'h500 + 32'(4 * k);
            req_write = 1'b0;
            req_size  = HSIZE_WORD;
            hready_m  = (k == 5);
            @(negedge clk);
            if (k == 4) begin
                total++;
                if ({req_ready0, busy0} !== 2'b01) begin
                    bad++; $display("FAIL full_not_ready got=%b want=01", {req_ready0, busy0});
                end
            end
            if (k == 5) begin
                total++;
                if (req_ready0 !== 1'b1) begin
                    bad++; $display("FAIL full_push_pop_ready got=%b want=1", req_ready0);
                end
            end
            if (k == 6) begin
                total++;
                if ({htrans0, haddr0} !== {HTRANS_NONSEQ, 32'h500}) begin
                    bad++; $display("FAIL full_head_issue got=%h want=%h", {htrans0, haddr0},
                                    {HTRANS_NONSEQ, 32'h500});
                end
            end
        end
        cyc();
        req_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        exp = {2'b00, 32'h0, 3'd2, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h0};
        obs = {htrans0, haddr0, hsize0, hwrite0, hburst0, hwdata0, rsp_valid0, rsp_rdata0,
               rsp_error0, busy0, err_count0};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL midreset_values got=%h want=%h", obs, exp); end
        cyc();
        hready_m = 1'b1;
        cyc();
        reset_n = 1'b1;
        repeat (6) cyc();
        total++;
        if ({req_ready0, busy0, htrans0} !== {1'b1, 1'b0, HTRANS_IDLE}) begin
            bad++; $display("FAIL after_reset_idle got=%b want=%b", {req_ready0, busy0, htrans0},
                            {1'b1, 1'b0, HTRANS_IDLE});
        end
        total++;
        if (rsp0_q.size() != 0) begin
            bad++; $display("FAIL lost_req_rsp got=%0d want=0", rsp0_q.size());
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_back_to_back();
        test_error_retry();
        test_flush();
        test_illegal();
        test_ce_gate();
        test_fifo_full_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
